seq_detector_param: RTL and testbench
=====================================

// Module: seq_detector_param
// PURPOSE
//  Programmable serial pattern detector. Compares a gated 1-bit stream against a
//  runtime-loadable PAT_W-bit pattern and reports matches two ways:
//  - Mealy: same cycle, combinational.
//  - Moore: one cycle later, registered.
//  Supports overlapping and non-overlapping detection. Sits between a serial
//  source and control logic that counts or acts on matches.
// PARAMETERS
//  PAT_W    4   pattern length in bits (>=2); pattern MSB is the oldest bit
//  RST_PAT  0   pattern register value after reset
//  CNT_W    8   match counter width (used only with SEQ_MATCH_CNT_EN)
// PORTS
//  clk         in   1      clock, rising edge
//  rst         in   1      asynchronous, active-high reset
//  din_valid   in   1      din is sampled only when 1
//  din         in   1      serial data bit
//  overlap     in   1      1: overlapping detection; 0: non-overlapping
//  pat_load    in   1      load pat_in into pattern register; flushes history
//  pat_in      in   PAT_W  new pattern
//  dout_mealy  out  1      combinational match flag for the current din
//  dout_moore  out  1      registered dout_mealy, 1-cycle latency
//  busy_fill   out  1      1 while fewer than PAT_W-1 valid bits are held
//  match_cnt   out  CNT_W  saturating match count (SEQ_MATCH_CNT_EN only)
// BEHAVIOUR
//  Reset: pattern=RST_PAT, history=0, fill=0, state=FILL.
//   Outputs after reset: dout_moore=0, busy_fill=1, match_cnt=0, dout_mealy=0.
//  Registers:
//   - hist[PAT_W-2:0]: last valid bits, LSB newest.
//   - fill: 0..PAT_W-1, width $clog2(PAT_W).
//  FSM, two states:
//   FILL: fill<PAT_W-1; busy_fill=1; dout_mealy forced 0.
//    Each valid bit shifts into hist and increments fill.
//    Move to RUN when fill reaches PAT_W-1.
//   RUN: dout_mealy = din_valid & ({hist,din}==pattern) & ~pat_load.
//    Each valid bit shifts into hist.
//    On a match with overlap=0: fill:=0, go to FILL.
//     History bits are not reused, so the next match needs PAT_W fresh bits.
//    On a match with overlap=1: stay in RUN; a match is possible on the very
//     next valid bit.
//  din_valid=0: no state change; dout_mealy=0.
//  pat_load=1 (either state):
//   - pattern:=pat_in, fill:=0, state:=FILL; hist not cleared (masked by fill).
//   - din is discarded in that cycle; load has priority over a coincident
//     valid bit.
//   - No match is reported in the load cycle.
//  overlap is sampled only on a matching cycle; changing it mid-stream is legal.
//  dout_moore <= dout_mealy every cycle; it is 0 in the cycle after reset release.
//  Reset asserted mid-stream: immediate return to reset values, no residual
//   match. dout_mealy goes low combinationally because state=FILL.
// CONFIGURATION
//  SEQ_MATCH_CNT_EN defined:
//   - match_cnt increments on each cycle dout_mealy=1.
//   - Saturates at 2**CNT_W-1, no wrap.
//   - Cleared by rst only; pat_load does not clear it.
//  SEQ_MATCH_CNT_EN undefined:
//   - match_cnt port is absent and CNT_W is ignored.
//   - No counter logic is built.
// TESTING
//  1. PAT_W=4, pattern 1011, overlap=1; stream 1,0,1,1,0,1,1
//     -> dout_mealy high on bits 4 and 7; dout_moore high one cycle after each.
//  2. Same stream with overlap=0 -> match on bit 4 only; busy_fill returns to 1
//     after bit 4.
//  3. Pattern 1111, overlap=1; seven consecutive 1s -> matches on bits 4,5,6,7.
//     With overlap=0 -> match on bit 4 only; bits 5..7 refill the history.
//  4. Stream 1,0,1 then din_valid=0 for 3 cycles, then 1 -> one match on the
//     4th valid bit; dout_mealy=0 during the gap.
//  5. pat_load(0110) coincident with a bit completing a 1011 match
//     -> no match that cycle, busy_fill=1.
//     Then 0,1,1,0 -> match on the 4th bit.
//  6. CNT_W=2 with SEQ_MATCH_CNT_EN: 5 matches -> match_cnt stays at 3.
//     Assert rst mid-pattern -> match_cnt=0, dout_moore=0, busy_fill=1 immediately.

Source files
------------

// File: rtl/seq_detector_param.sv
// Programmable serial pattern detector with same-cycle (Mealy) and registered (Moore) match flags.
// Optional saturating match counter is built only when SEQ_MATCH_CNT_EN is defined.
module seq_detector_param #(
    parameter int                PAT_W   = 4,
    parameter logic [PAT_W-1:0]  RST_PAT = '0,
    parameter int                CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    input  logic             din,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    output logic             dout_mealy,
    output logic             dout_moore,
    output logic             busy_fill
`ifdef SEQ_MATCH_CNT_EN
    ,
    output logic [CNT_W-1:0] match_cnt
`endif
);

    localparam int                FILL_W    = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);

    typedef enum logic {
        FILL,
        RUN
    } state_t;

    state_t             state;
    logic [PAT_W-2:0]   hist;
    logic [FILL_W-1:0]  fill;
    logic [PAT_W-1:0]   pattern;
    logic [PAT_W-1:0]   window;
    logic               match;

    // Oldest held bit lands in the pattern MSB, the live input bit in the LSB.
    assign window     = {hist, din};
    assign match      = (state == RUN) && din_valid && (window == pattern) && !pat_load;
    assign dout_mealy = match;
    assign busy_fill  = (state == FILL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FILL;
            hist       <= '0;
            fill       <= '0;
            pattern    <= RST_PAT;
            dout_moore <= 1'b0;
        end else begin
            dout_moore <= match;
            if (pat_load) begin
                // Stale history stays in place but is masked by the restarted fill count.
                pattern <= pat_in;
                fill    <= '0;
                state   <= FILL;
            end else if (din_valid) begin
                hist <= window[PAT_W-2:0];
                case (state)
                    FILL: begin
                        fill <= fill + FILL_W'(1);
                        if (fill + FILL_W'(1) == FILL_FULL)
                            state <= RUN;
                    end
                    RUN: begin
                        if (match && !overlap) begin
                            fill  <= '0;
                            state <= FILL;
                        end
                    end
                    default: state <= FILL;
                endcase
            end
        end
    end

`ifdef SEQ_MATCH_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            match_cnt <= '0;
        else if (match && (match_cnt != {CNT_W{1'b1}}))
            match_cnt <= match_cnt + CNT_W'(1);
    end
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param: directed scenarios plus randomized traffic
// compared against a queue-based reference model (counter checks need SEQ_MATCH_CNT_EN).
module tb_seq_detector_param;

    localparam int PAT_W   = 4;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             din_valid;
    logic             din;
    logic             overlap;
    logic             pat_load;
    logic [PAT_W-1:0] pat_in;
    logic             dout_mealy;
    logic             dout_moore;
    logic             busy_fill;
`ifdef SEQ_MATCH_CNT_EN
    logic [CNT_W-1:0] match_cnt;
`endif

    always #5 clk = ~clk;

    seq_detector_param #(
        .PAT_W   (PAT_W),
        .RST_PAT ('0),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din        (din),
        .overlap    (overlap),
        .pat_load   (pat_load),
        .pat_in     (pat_in),
        .dout_mealy (dout_mealy),
        .dout_moore (dout_moore),
        .busy_fill  (busy_fill)
`ifdef SEQ_MATCH_CNT_EN
        ,
        .match_cnt  (match_cnt)
`endif
    );

    int checks = 0;
    int passes = 0;

    // Reference model: the fresh valid bits since the last flush (oldest first), capped at PAT_W-1.
    logic             hq[$];
    logic [PAT_W-1:0] m_pat;
    int               m_cnt;

    logic o_mealy, o_busy, o_moore, e_mealy, e_busy;
    int   o_cnt;

    function automatic logic model_match(input logic v, input logic d, input logic ld);
        logic [PAT_W-1:0] w;
        if (!v || ld || hq.size() != PAT_W - 1)
            return 1'b0;
        for (int i = 0; i < PAT_W - 1; i++)
            w[PAT_W-1-i] = hq[i];
        w[0] = d;
        return (w == m_pat);
    endfunction

    task automatic model_reset();
        hq.delete();
        m_pat = '0;
        m_cnt = 0;
    endtask

    task automatic model_commit(input logic v, input logic d, input logic ov,
                                input logic ld, input logic [PAT_W-1:0] p);
        logic m;
        m = model_match(v, d, ld);
        if (ld) begin
            m_pat = p;
            hq.delete();
        end else if (v) begin
            hq.push_back(d);
            if (hq.size() > PAT_W - 1)
                void'(hq.pop_front());
            if (m && !ov)
                hq.delete();
        end
        if (m && m_cnt < CNT_MAX)
            m_cnt++;
    endtask

    // Drives one clock cycle from a negedge, samples the DUT and records model expectations.
    task automatic cycle(input logic v, input logic d, input logic ov,
                         input logic ld, input logic [PAT_W-1:0] p);
        din_valid = v;
        din       = d;
        overlap   = ov;
        pat_load  = ld;
        pat_in    = p;
        #1;
        o_mealy = dout_mealy;
        o_busy  = busy_fill;
        e_mealy = model_match(v, d, ld);
        e_busy  = (hq.size() < PAT_W - 1);
        @(posedge clk);
        model_commit(v, d, ov, ld, p);
        #1;
        o_moore = dout_moore;
`ifdef SEQ_MATCH_CNT_EN
        o_cnt = int'(match_cnt);
`else
        o_cnt = 0;
`endif
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        din_valid = 1'b0;
        din = 1'b0;
        overlap = 1'b0;
        pat_load = 1'b0;
        pat_in = '0;
        #1;
        checks++;
        if ({dout_mealy, dout_moore, busy_fill} !== 3'b001)
            $display("[TB] FAIL reset_outputs: got mealy/moore/busy=%b%b%b want 001",
                     dout_mealy, dout_moore, busy_fill);
        else passes++;
`ifdef SEQ_MATCH_CNT_EN
        checks++;
        if (match_cnt !== '0)
            $display("[TB] FAIL reset_cnt: got %0d want 0", match_cnt);
        else passes++;
`endif
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
        checks++;
        if ({o_moore, o_busy} !== 2'b01)
            $display("[TB] FAIL post_reset: got moore/busy=%b%b want 01", o_moore, o_busy);
        else passes++;
    endtask

    task automatic test_patterns();
        logic [PAT_W-1:0] cp [4]  = '{4'b1011, 4'b1011, 4'b1111, 4'b1111};
        logic             cov [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [6:0]       cs [4]  = '{7'b1011011, 7'b1011011, 7'b1111111, 7'b1111111};
        logic [6:0]       cexp [4] = '{7'b0001001, 7'b0001000, 7'b0001111, 7'b0001000};
        logic [6:0]       seen;
        logic             busy5;
        for (int c = 0; c < 4; c++) begin
            cycle(1'b0, 1'b0, cov[c], 1'b1, cp[c]);
            seen  = '0;
            busy5 = 1'b0;
            for (int i = 0; i < 7; i++) begin
                cycle(1'b1, cs[c][6-i], cov[c], 1'b0, '0);
                seen[6-i] = o_mealy;
                if (i == 4) busy5 = o_busy;
                checks++;
                if ({o_mealy, o_busy, o_moore} !== {e_mealy, e_busy, e_mealy})
                    $display("[TB] FAIL pattern%0d_bit%0d: got mealy/busy/moore=%b%b%b want %b%b%b",
                             c, i + 1, o_mealy, o_busy, o_moore, e_mealy, e_busy, e_mealy);
                else passes++;
            end
            checks++;
            if (seen !== cexp[c])
                $display("[TB] FAIL pattern%0d_match_positions: got %b want %b", c, seen, cexp[c]);
            else passes++;
            if (!cov[c]) begin
                checks++;
                if (busy5 !== 1'b1)
                    $display("[TB] FAIL pattern%0d_busy_after_match: got %b want 1", c, busy5);
                else passes++;
            end
        end
    endtask

    task automatic test_gap();
        logic       gv [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic       gd [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [6:0] seen = '0;
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'b1011);
        for (int i = 0; i < 7; i++) begin
            cycle(gv[i], gd[i], 1'b1, 1'b0, '0);
            seen[6-i] = o_mealy;
            checks++;
            if ({o_mealy, o_busy, o_moore} !== {e_mealy, e_busy, e_mealy})
                $display("[TB] FAIL gap_cycle%0d: got mealy/busy/moore=%b%b%b want %b%b%b",
                         i, o_mealy, o_busy, o_moore, e_mealy, e_busy, e_mealy);
            else passes++;
        end
        checks++;
        if (seen !== 7'b0000001)
            $display("[TB] FAIL gap_match_positions: got %b want 0000001", seen);
        else passes++;
    endtask

    task automatic test_load();
        logic       ld_bits [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [3:0] seen = '0;
        logic       first_busy = 1'b0;
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'b1011);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, '0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 4'b0110);
        checks++;
        if ({o_mealy, o_moore} !== 2'b00)
            $display("[TB] FAIL load_cycle_no_match: got mealy/moore=%b%b want 00", o_mealy, o_moore);
        else passes++;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, ld_bits[i], 1'b1, 1'b0, '0);
            seen[3-i] = o_mealy;
            if (i == 0) first_busy = o_busy;
            checks++;
            if ({o_mealy, o_busy, o_moore} !== {e_mealy, e_busy, e_mealy})
                $display("[TB] FAIL load_bit%0d: got mealy/busy/moore=%b%b%b want %b%b%b",
                         i + 1, o_mealy, o_busy, o_moore, e_mealy, e_busy, e_mealy);
            else passes++;
        end
        checks++;
        if (first_busy !== 1'b1)
            $display("[TB] FAIL load_busy_after: got %b want 1", first_busy);
        else passes++;
        checks++;
        if (seen !== 4'b0001)
            $display("[TB] FAIL load_match_positions: got %b want 0001", seen);
        else passes++;
    endtask

    task automatic test_random();
        logic             v, d, ov, ld;
        logic [PAT_W-1:0] p;
        int               errs = 0;
        cycle(1'b0, 1'b0, 1'b1, 1'b1, PAT_W'($urandom_range(0, (1 << PAT_W) - 1)));
        for (int i = 0; i < 400; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            d  = 1'($urandom_range(0, 1));
            ov = 1'($urandom_range(0, 1));
            ld = ($urandom_range(0, 29) == 0);
            p  = PAT_W'($urandom_range(0, (1 << PAT_W) - 1));
            cycle(v, d, ov, ld, p);
            checks++;
            if ({o_mealy, o_busy, o_moore} !== {e_mealy, e_busy, e_mealy}) begin
                errs++;
                if (errs <= 10)
                    $display("[TB] FAIL random_cycle%0d: got mealy/busy/moore=%b%b%b want %b%b%b",
                             i, o_mealy, o_busy, o_moore, e_mealy, e_busy, e_mealy);
            end else passes++;
`ifdef SEQ_MATCH_CNT_EN
            checks++;
            if (o_cnt != m_cnt)
                $display("[TB] FAIL random_cnt%0d: got %0d want %0d", i, o_cnt, m_cnt);
            else passes++;
`endif
        end
    endtask

    task automatic test_counter();
        pulse_reset();
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'b1111);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
            checks++;
            if ({o_mealy, o_moore} !== {e_mealy, e_mealy})
                $display("[TB] FAIL counter_bit%0d: got mealy/moore=%b%b want %b%b",
                         i + 1, o_mealy, o_moore, e_mealy, e_mealy);
            else passes++;
        end
`ifdef SEQ_MATCH_CNT_EN
        checks++;
        if (match_cnt !== 2'd3)
            $display("[TB] FAIL counter_saturate: got %0d want 3", match_cnt);
        else passes++;
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'b0110);
        checks++;
        if (match_cnt !== 2'd3)
            $display("[TB] FAIL counter_kept_on_load: got %0d want 3", match_cnt);
        else passes++;
`endif
    endtask

    task automatic test_reset_midstream();
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'b1111);
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
        din_valid = 1'b1;
        din       = 1'b1;
        pat_load  = 1'b0;
        #1;
        checks++;
        if (dout_mealy !== 1'b1)
            $display("[TB] FAIL midstream_pre_reset_match: got %b want 1", dout_mealy);
        else passes++;
        rst = 1'b1;
        #1;
        checks++;
        if ({dout_mealy, dout_moore, busy_fill} !== 3'b001)
            $display("[TB] FAIL midstream_reset: got mealy/moore/busy=%b%b%b want 001",
                     dout_mealy, dout_moore, busy_fill);
        else passes++;
`ifdef SEQ_MATCH_CNT_EN
        checks++;
        if (match_cnt !== '0)
            $display("[TB] FAIL midstream_reset_cnt: got %0d want 0", match_cnt);
        else passes++;
`endif
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
        checks++;
        if ({o_mealy, o_busy, o_moore} !== 3'b010)
            $display("[TB] FAIL after_midstream_reset: got mealy/busy/moore=%b%b%b want 010",
                     o_mealy, o_busy, o_moore);
        else passes++;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_patterns();
        test_gap();
        test_load();
        test_random();
        test_counter();
        test_reset_midstream();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

endmodule
